irq_controller: RTL and testbench
=================================

# irq_controller

Interrupt source aggregator directly upstream of the exception handler. Collects NSRC asynchronous peripheral interrupt lines and synchronises, edge-latches, masks and routes each to the processor's IRQ or FIQ request input. It also captures the ID of the winning source when the exception handler asserts IRQAssert/FIQAssert, so the handler software can read which source caused the exception. Software configures and acknowledges sources through a small word-wide register port.

## Interface
- NSRC, 8: number of interrupt sources (1..16); source 0 has highest priority.
- clk  in  1  processor clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- SrcIn  in  NSRC  raw interrupt lines, asynchronous to clk, active-high.
- IRQAssert  in  1  one-cycle pulse from the exception handler when the IRQ exception is taken.
- FIQAssert  in  1  one-cycle pulse from the exception handler when the FIQ exception is taken.
- RegWE  in  1  register write strobe.
- RegAddr  in  3  register select.
- RegWD  in  32  write data; bits above NSRC ignored.
- RegRD  out  32  read data, combinational from RegAddr; unused upper bits 0.
- IRQ  out  1  registered level request to the exception handler.
- FIQ  out  1  registered level request to the exception handler.

## Operation
- Per source: 2-flop synchroniser (Sync1, Sync2), plus a delayed copy Sync2D for edge detection; Rise = Sync2 & ~Sync2D.
- Register map (RegAddr):
  - 0 RAW: RO, Sync2 vector.
  - 1 PEND: read latched edge pending bits; write-1-to-clear.
  - 2 ENABLE: RW mask, 1 = enabled.
  - 3 FIQSEL: RW, 1 = route to FIQ, 0 = route to IRQ.
  - 4 EDGE: RW, 1 = edge-triggered, 0 = level-sensitive.
  - 5 IRQID: RO, {Valid at bit 31, ID at bits 3:0}.
  - 6 FIQID: RO, same format.
  - 7: reads 0.
- Writes to RO addresses and to address 7 are ignored.
- Pending bit for edge sources:
  - Set on Rise.
  - Cleared by a PEND write with a 1 in that bit.
  - Set wins over a simultaneous clear.
  - PEND bits of level sources read 0 and never set.
- Clearing an EDGE bit also clears that source's PEND bit.
- Active[i] = ENABLE[i] & (EDGE[i] ? PEND[i] : Sync2[i]).
- Next IRQ = |(Active & ~FIQSEL). Next FIQ = |(Active & FIQSEL).
- ID capture:
  - On IRQAssert, IRQID is loaded with the lowest-indexed bit of (Active & ~FIQSEL) and Valid=1.
  - If no source is active (request withdrawn), IRQID gets Valid=0, ID=0.
  - FIQAssert loads FIQID the same way with FIQSEL.
  - IDs hold until the next assert pulse; reads have no side effects.
- Simultaneous IRQAssert and FIQAssert: both IDs are captured independently.
- The controller does not acknowledge sources. Software must clear PEND (edge) or quiesce the peripheral (level). IRQ/FIQ stay high until then.

## Timing
- Reset (asynchronous, reset_n low): every flop is cleared, so IRQ=FIQ=0, ENABLE=FIQSEL=EDGE=PEND=0, IRQID=FIQID=0. RegRD then reflects the zeroed registers. Reset mid-pending discards all pending state.
- Latency, counting from the first clk edge at which SrcIn is seen high (edge 1):
  - Sync2 is high after edge 2.
  - Level source: IRQ/FIQ high after edge 3.
  - Edge source: PEND set after edge 3; IRQ/FIQ high after edge 4.
- Register write takes effect after the edge on which RegWE is sampled. Request outputs reflect it one edge later. Example: a PEND clear drops IRQ 2 edges after the write is sampled.
- ID capture completes at the edge that samples IRQAssert/FIQAssert, using Active from that same cycle.
- Source pulses shorter than 2 clk periods may be lost; this is the documented limitation.

## Structure
- Shared package irq_pkg:
  - Address constants IRQ_RAW..IRQ_FIQID.
  - Valid bit position (31) and ID width (4).
  - Function prio_enc(vector) returning {valid, id}.
- Sub-module irq_sync: one per source, generated NSRC times. Contains Sync1/Sync2/Sync2D and Rise output, with asynchronous active-low reset.

## Test plan
- Reset: drive reset_n low mid-operation with PEND=0x05 and IRQ=1 → all outputs and registers read 0 immediately; IRQ=0.
- Level IRQ: ENABLE=0x01, EDGE=0, SrcIn[0] high → IRQ=1 after edge 3. Drop SrcIn[0] → IRQ=0 three edges later.
- Edge FIQ with W1C:
  - Setup: EDGE=0x04, FIQSEL=0x04, ENABLE=0x04; pulse SrcIn[2] for 3 cycles → FIQ=1 after edge 4 and stays high; PEND reads 0x04.
  - Write PEND=0x04 → FIQ=0 two edges later.
- Set-over-clear: a Rise on source 1 coincides with a PEND write of 0x02 → PEND[1] stays 1.
- Priority capture: sources 3 and 5 active on IRQ; pulse IRQAssert → IRQID reads 0x80000003.
- Withdrawn request: clear the source, then pulse IRQAssert → IRQID reads 0; FIQID is unchanged.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared register map, ID register layout and priority encoder for the interrupt controller.
package irq_pkg;

    localparam logic [2:0] IRQ_RAW    = 3'd0;
    localparam logic [2:0] IRQ_PEND   = 3'd1;
    localparam logic [2:0] IRQ_ENABLE = 3'd2;
    localparam logic [2:0] IRQ_FIQSEL = 3'd3;
    localparam logic [2:0] IRQ_EDGE   = 3'd4;
    localparam logic [2:0] IRQ_IRQID  = 3'd5;
    localparam logic [2:0] IRQ_FIQID  = 3'd6;

    localparam int VALID_BIT = 31;
    localparam int ID_W      = 4;
    localparam int MAX_SRC   = 16;

    // Lowest set bit wins; result is {valid, id}, all zero when nothing is set.
    function automatic logic [ID_W:0] prio_enc(input logic [MAX_SRC-1:0] vec);
        logic [ID_W:0] res;
        res = '0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                res = {1'b1, ID_W'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchroniser for one asynchronous interrupt line, with rising-edge detect.
module irq_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic src_in,
    output logic sync2,
    output logic rise
);

    logic sync1;
    logic sync2d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync2d <= 1'b0;
        end else begin
            sync1  <= src_in;
            sync2  <= sync1;
            sync2d <= sync2;
        end
    end

    assign rise = sync2 & ~sync2d;

endmodule

// File: rtl/irq_controller.sv
// Interrupt aggregator: synchronises, latches, masks and routes sources to IRQ/FIQ,
// and captures the winning source ID when the exception handler takes the exception.
module irq_controller
    import irq_pkg::*;
#(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NSRC-1:0] SrcIn,
    input  logic            IRQAssert,
    input  logic            FIQAssert,
    input  logic            RegWE,
    input  logic [2:0]      RegAddr,
    input  logic [31:0]     RegWD,
    output logic [31:0]     RegRD,
    output logic            IRQ,
    output logic            FIQ
);

    logic [NSRC-1:0] sync2;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] enable;
    logic [NSRC-1:0] fiqsel;
    logic [NSRC-1:0] edge_sel;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] pend_nxt;
    logic [NSRC-1:0] pend_clr;
    logic [NSRC-1:0] edge_keep;
    logic [NSRC-1:0] active;
    logic [NSRC-1:0] wd;
    logic            irq_valid;
    logic            fiq_valid;
    logic [ID_W-1:0] irq_id;
    logic [ID_W-1:0] fiq_id;
    logic            wr_pend;
    logic            wr_enable;
    logic            wr_fiqsel;
    logic            wr_edge;
    logic            unused_wd;

    for (genvar i = 0; i < NSRC; i++) begin : g_sync
        irq_sync u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .src_in  (SrcIn[i]),
            .sync2   (sync2[i]),
            .rise    (rise[i])
        );
    end

    assign wd        = RegWD[NSRC-1:0];
    assign unused_wd = ^RegWD[31:NSRC];

    assign wr_pend   = RegWE && (RegAddr == IRQ_PEND);
    assign wr_enable = RegWE && (RegAddr == IRQ_ENABLE);
    assign wr_fiqsel = RegWE && (RegAddr == IRQ_FIQSEL);
    assign wr_edge   = RegWE && (RegAddr == IRQ_EDGE);

    // A new rise beats a simultaneous W1C; dropping a source to level mode discards its pending bit.
    assign pend_clr  = wr_pend ? wd : '0;
    assign edge_keep = wr_edge ? (edge_sel & wd) : edge_sel;
    assign pend_nxt  = ((pend & ~pend_clr) | rise) & edge_keep;

    assign active = enable & ((edge_sel & pend) | (~edge_sel & sync2));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable    <= '0;
            fiqsel    <= '0;
            edge_sel  <= '0;
            pend      <= '0;
            IRQ       <= 1'b0;
            FIQ       <= 1'b0;
            irq_valid <= 1'b0;
            irq_id    <= '0;
            fiq_valid <= 1'b0;
            fiq_id    <= '0;
        end else begin
            if (wr_enable) enable   <= wd;
            if (wr_fiqsel) fiqsel   <= wd;
            if (wr_edge)   edge_sel <= wd;
            pend <= pend_nxt;
            IRQ  <= |(active & ~fiqsel);
            FIQ  <= |(active & fiqsel);
            if (IRQAssert) {irq_valid, irq_id} <= prio_enc(MAX_SRC'(active & ~fiqsel));
            if (FIQAssert) {fiq_valid, fiq_id} <= prio_enc(MAX_SRC'(active & fiqsel));
        end
    end

    always_comb begin
        RegRD = '0;
        case (RegAddr)
            IRQ_RAW:    RegRD = 32'(sync2);
            IRQ_PEND:   RegRD = 32'(pend);
            IRQ_ENABLE: RegRD = 32'(enable);
            IRQ_FIQSEL: RegRD = 32'(fiqsel);
            IRQ_EDGE:   RegRD = 32'(edge_sel);
            IRQ_IRQID:  RegRD = {irq_valid, {(VALID_BIT-ID_W){1'b0}}, irq_id};
            IRQ_FIQID:  RegRD = {fiq_valid, {(VALID_BIT-ID_W){1'b0}}, fiq_id};
            default:    RegRD = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
// Scenario bench for irq_controller: expected values queued with the stimulus, popped when the DUT answers.
module tb_irq_controller;

    localparam int NSRC = 8;

    logic            clk;
    logic            reset_n;
    logic [NSRC-1:0] SrcIn;
    logic            IRQAssert;
    logic            FIQAssert;
    logic            RegWE;
    logic [2:0]      RegAddr;
    logic [31:0]     RegWD;
    logic [31:0]     RegRD;
    logic            IRQ;
    logic            FIQ;

    logic [31:0] exp_q[$];
    logic [31:0] got;
    logic [31:0] e;
    int          vectors;
    int          miscompares;

    irq_controller #(.NSRC(NSRC)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .SrcIn     (SrcIn),
        .IRQAssert (IRQAssert),
        .FIQAssert (FIQAssert),
        .RegWE     (RegWE),
        .RegAddr   (RegAddr),
        .RegWD     (RegWD),
        .RegRD     (RegRD),
        .IRQ       (IRQ),
        .FIQ       (FIQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        RegWE   = 1'b1;
        RegAddr = a;
        RegWD   = d;
        @(posedge clk);
        #1;
        RegWE = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        RegAddr = a;
        #1;
        d = RegRD;
    endtask

    task automatic test_reset();
        for (int a = 0; a < 8; a++) begin
            exp_q.push_back(32'h0);
            rd(3'(a), got);
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL reset_reg%0d got=%h exp=%h", a, got, e);
            end
        end
        exp_q.push_back(32'h0);
        got = {30'b0, IRQ, FIQ};
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL reset_irq_fiq got=%h exp=%h", got, e);
        end
    endtask

    task automatic test_level_irq();
        reg_wr(3'd2, 32'h01);
        @(negedge clk);
        SrcIn[0] = 1'b1;
        exp_q.push_back(32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        got = {31'b0, IRQ};
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL level_irq_edge2 got=%h exp=%h", got, e);
        end
        exp_q.push_back(32'h1);
        @(posedge clk);
        #1;
        got = {31'b0, IRQ};
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL level_irq_edge3 got=%h exp=%h", got, e);
        end
        exp_q.push_back(32'h01);
        rd(3'd0, got);
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL level_raw got=%h exp=%h", got, e);
        end
        @(negedge clk);
        SrcIn[0] = 1'b0;
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        got = {31'b0, IRQ};
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL level_drop_edge2 got=%h exp=%h", got, e);
        end
        @(posedge clk);
        #1;
        got = {31'b0, IRQ};
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL level_drop_edge3 got=%h exp=%h", got, e);
        end
        reg_wr(3'd2, 32'h00);
    endtask

    task automatic test_edge_fiq();
        reg_wr(3'd4, 32'h04);
        reg_wr(3'd3, 32'h04);
        reg_wr(3'd2, 32'h04);
        @(negedge clk);
        SrcIn[2] = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h04);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        SrcIn[2] = 1'b0;
        got = {31'b0, FIQ};
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL edge_fiq_edge3 got=%h exp=%h", got, e);
        end
        rd(3'd1, got);
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL edge_pend_edge3 got=%h exp=%h", got, e);
        end
        exp_q.push_back(32'h1);
        @(posedge clk);
        #1;
        got = {31'b0, FIQ};
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL edge_fiq_edge4 got=%h exp=%h", got, e);
        end
        exp_q.push_back(32'h2);
        repeat (4) @(posedge clk);
        #1;
        got = {30'b0, FIQ, IRQ};
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL edge_fiq_held got=%h exp=%h", got, e);
        end
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        reg_wr(3'd1, 32'h04);
        got = {31'b0, FIQ};
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL w1c_fiq_edge1 got=%h exp=%h", got, e);
        end
        @(posedge clk);
        #1;
        got = {31'b0, FIQ};
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL w1c_fiq_edge2 got=%h exp=%h", got, e);
        end
        rd(3'd1, got);
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL w1c_pend got=%h exp=%h", got, e);
        end
        reg_wr(3'd2, 32'h00);
        reg_wr(3'd3, 32'h00);
    endtask

    task automatic test_set_over_clear();
        reg_wr(3'd4, 32'h02);
        @(negedge clk);
        SrcIn[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        RegWE   = 1'b1;
        RegAddr = 3'd1;
        RegWD   = 32'h02;
        exp_q.push_back(32'h02);
        @(posedge clk);
        #1;
        RegWE = 1'b0;
        rd(3'd1, got);
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL set_over_clear got=%h exp=%h", got, e);
        end
        exp_q.push_back(32'h00);
        reg_wr(3'd4, 32'h00);
        rd(3'd1, got);
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL edge_clr_pend got=%h exp=%h", got, e);
        end
        @(negedge clk);
        SrcIn[1] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        SrcIn[1] = 1'b1;
        exp_q.push_back(32'h00);
        repeat (5) @(posedge clk);
        #1;
        rd(3'd1, got);
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL level_no_pend got=%h exp=%h", got, e);
        end
        SrcIn[1] = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_priority_capture();
        reg_wr(3'd2, 32'h68);
        reg_wr(3'd3, 32'h40);
        @(negedge clk);
        SrcIn = 8'h68;
        exp_q.push_back(32'h3);
        repeat (4) @(posedge clk);
        #1;
        got = {30'b0, FIQ, IRQ};
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL prio_requests got=%h exp=%h", got, e);
        end
        @(negedge clk);
        IRQAssert = 1'b1;
        FIQAssert = 1'b1;
        exp_q.push_back(32'h80000003);
        exp_q.push_back(32'h80000006);
        @(posedge clk);
        #1;
        IRQAssert = 1'b0;
        FIQAssert = 1'b0;
        rd(3'd5, got);
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL prio_irqid got=%h exp=%h", got, e);
        end
        rd(3'd6, got);
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL prio_fiqid got=%h exp=%h", got, e);
        end
    endtask

    task automatic test_withdrawn();
        @(negedge clk);
        SrcIn = 8'h40;
        exp_q.push_back(32'h2);
        repeat (4) @(posedge clk);
        #1;
        got = {30'b0, FIQ, IRQ};
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL withdrawn_requests got=%h exp=%h", got, e);
        end
        @(negedge clk);
        IRQAssert = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h80000006);
        @(posedge clk);
        #1;
        IRQAssert = 1'b0;
        rd(3'd5, got);
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL withdrawn_irqid got=%h exp=%h", got, e);
        end
        rd(3'd6, got);
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL withdrawn_fiqid got=%h exp=%h", got, e);
        end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h0);
        reg_wr(3'd5, 32'hFFFF_FFFF);
        reg_wr(3'd0, 32'hFFFF_FFFF);
        reg_wr(3'd7, 32'hFFFF_FFFF);
        rd(3'd5, got);
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL ro_irqid_write got=%h exp=%h", got, e);
        end
        rd(3'd0, got);
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL ro_raw_write got=%h exp=%h", got, e);
        end
        rd(3'd7, got);
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL addr7_read got=%h exp=%h", got, e);
        end
        @(negedge clk);
        SrcIn = '0;
        reg_wr(3'd3, 32'h00);
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset_midop();
        reg_wr(3'd4, 32'h05);
        reg_wr(3'd2, 32'h05);
        @(negedge clk);
        SrcIn = 8'h05;
        repeat (4) @(posedge clk);
        #1;
        SrcIn = '0;
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h05);
        got = {31'b0, IRQ};
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL midop_irq_before got=%h exp=%h", got, e);
        end
        rd(3'd1, got);
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL midop_pend_before got=%h exp=%h", got, e);
        end
        @(negedge clk);
        reset_n = 1'b0;
        exp_q.push_back(32'h0);
        #1;
        got = {30'b0, IRQ, FIQ};
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL midop_reset_outputs got=%h exp=%h", got, e);
        end
        for (int a = 1; a < 7; a++) begin
            exp_q.push_back(32'h0);
            rd(3'(a), got);
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL midop_reset_reg%0d got=%h exp=%h", a, got, e);
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        SrcIn       = '0;
        IRQAssert   = 1'b0;
        FIQAssert   = 1'b0;
        RegWE       = 1'b0;
        RegAddr     = '0;
        RegWD       = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset_n = 1'b1;
        test_level_irq();
        test_edge_fiq();
        test_set_over_clear();
        test_priority_capture();
        test_withdrawn();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
